// File: rtl/boot_status_pkg.sv
// Shared encodings for the boot/status controller: POR FSM states and LED display modes.
// No latency and no flow control; this package holds types only.
package boot_status_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    COUNT     = 2'd1,
    RUN       = 2'd2
  } por_state_e;

  typedef enum logic [1:0] {
    LED_HB_EVT = 2'd0,
    LED_EVT    = 2'd1,
    LED_BLINK  = 2'd2,
    LED_OFF    = 2'd3
  } led_mode_e;

endpackage

// File: rtl/evt_channel.sv
// One event channel: 2-flop sync, rising-edge detect, sticky flag and saturating count.
// Sticky/count update 3 clocks after the input rises; there is no backpressure and edges are dropped while hold=1.
module evt_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             evt_async,
  input  logic             clr,
  input  logic             hold,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // [0],[1] synchronise; [2] is the previous synchronised value
  logic [2:0]       sync_q;
  logic             evt_edge;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  assign evt_edge = sync_q[1] & ~sync_q[2] & ~hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[1:0], evt_async};
      // A clear coinciding with an edge restarts the count at one
      if (evt_edge) begin
        sticky_q <= 1'b1;
        if (clr)
          cnt_q <= CNT_W'(1);
        else if (cnt_q != CNT_MAX)
          cnt_q <= cnt_q + CNT_W'(1);
      end else if (clr) begin
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end
    end
  end

  assign sticky = sticky_q;
  assign cnt    = cnt_q;

endmodule

// File: rtl/boot_status_ctrl.sv
// Board boot/status block: PLL-lock gated POR sequencer, event latches/counters and a registered LED driver.
// sys_rst releases 2^POR_W-1 locked cycles after lock is synchronised; led has one cycle latency; no backpressure.
module boot_status_ctrl
  import boot_status_pkg::*;
#(
  parameter int POR_W   = 20,
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 8,
  parameter int HB_W    = 30,
  parameter int LED_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     pll_locked,
  input  logic [NUM_EVT-1:0]       evt_in,
  input  logic [NUM_EVT-1:0]       evt_clr,
  input  logic [1:0]               led_mode,
  output logic                     sys_rst,
  output logic [NUM_EVT-1:0]       evt_sticky,
  output logic [NUM_EVT*CNT_W-1:0] evt_cnt,
  output logic [LED_W-1:0]         led
);

  localparam logic [POR_W-1:0] POR_MAX = '1;

  // Asserts with reset_n, releases on a clock edge
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rst_sync_q <= '0;
    else
      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [1:0] lock_sync_q;
  logic       lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lock_sync_q <= '0;
    else
      lock_sync_q <= {lock_sync_q[0], pll_locked};
  end

  assign lock_s = lock_sync_q[1];

  por_state_e       state_q, state_d;
  logic [POR_W-1:0] por_cnt_q, por_cnt_d, por_cnt_inc;
  logic             sys_rst_q;

  assign por_cnt_inc = por_cnt_q + POR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOCK;
      por_cnt_q <= '0;
      sys_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      por_cnt_q <= por_cnt_d;
      // Leaving RUN asserts sys_rst on the same edge the FSM drops to WAIT_LOCK
      sys_rst_q <= !((state_q == RUN) && lock_s);
    end
  end

  always_comb begin
    state_d   = state_q;
    por_cnt_d = por_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        por_cnt_d = '0;
        if (lock_s)
          state_d = COUNT;
      end
      COUNT: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          por_cnt_d = '0;
        end else begin
          por_cnt_d = por_cnt_inc;
          if (por_cnt_inc == POR_MAX)
            state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          por_cnt_d = '0;
        end
      end
      default: begin
        state_d   = WAIT_LOCK;
        por_cnt_d = '0;
      end
    endcase
  end

  assign sys_rst = sys_rst_q;

  for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt
    evt_channel #(
      .CNT_W(CNT_W)
    ) u_evt_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .evt_async(evt_in[i]),
      .clr      (evt_clr[i]),
      .hold     (sys_rst_q),
      .sticky   (evt_sticky[i]),
      .cnt      (evt_cnt[i*CNT_W +: CNT_W])
    );
  end

  logic [HB_W-1:0]  hb_q;
  logic [LED_W-1:0] led_d, led_q;

  always_comb begin
    led_d = '0;
    case (led_mode)
      LED_HB_EVT: led_d = {hb_q[HB_W-1 -: LED_W-NUM_EVT], evt_sticky};
      LED_EVT:    led_d = LED_W'(evt_sticky);
      LED_BLINK:  led_d = {LED_W{hb_q[HB_W-1]}};
      LED_OFF:    led_d = '0;
      default:    led_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_q  <= '0;
      led_q <= '0;
    end else begin
      hb_q  <= hb_q + HB_W'(1);
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule
